cmos_inv_pipeline: RTL and testbench

//  Parametrised, registered successor to the single switch-level CMOS inverter.

---
 rtl/cmos_inv_pkg.sv | 22 ++
 rtl/cmos_inv_cell.sv | 22 ++
 rtl/cmos_inv_pipeline.sv | 146 ++++++++++++++
 tb/tb_cmos_inv_pipeline.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_inv_pkg.sv
// cmos_inv_pkg: shared constants, sizing helper and per-stage control type
// for the cmos_inv_pipeline slice.
`default_nettype none

package cmos_inv_pkg;

    localparam int MAX_DEPTH = 16;
    localparam int DEF_WIDTH = 8;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic valid;
        logic adv;
    } stage_ctl_t;

endpackage

`default_nettype wire

// File: rtl/cmos_inv_cell.sv
// cmos_inv_cell: WIDTH-bit combinational inverter built from one pmos pull-up
// and one nmos pull-down per bit.
`default_nettype none

module cmos_inv_cell #(
    parameter int WIDTH = 8
) (
    input  wire [WIDTH-1:0] x,
    output wire [WIDTH-1:0] y
);

    supply1 vdd;
    supply0 gnd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pmos u_pu (y[i], vdd, x[i]);
        nmos u_pd (y[i], gnd, x[i]);
    end

endmodule

`default_nettype wire

// File: rtl/cmos_inv_pipeline.sv
// cmos_inv_pipeline: DEPTH-stage valid/ready pipeline whose stages optionally invert
// via cmos_inv_cell banks. Optional parity tracking under CMOS_INV_PIPELINE_PARITY_EN.
`default_nettype none

module cmos_inv_pipeline
    import cmos_inv_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DEPTH    = 4,
    parameter logic [DEPTH-1:0] INV_MASK = 4'b0101
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          pol,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_cnt(DEPTH)-1:0]   count
`ifdef CMOS_INV_PIPELINE_PARITY_EN
    ,
    output logic                          out_par,
    output logic                          par_err
`endif
);

    stage_ctl_t         ctl [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   src_valid;
    logic [DEPTH-1:0]   load;
    logic [WIDTH-1:0]   stage_data [DEPTH];
    logic [WIDTH-1:0]   stage_in   [DEPTH];
    logic [WIDTH-1:0]   head_data;
    wire  [WIDTH-1:0]   pol_inv;
    logic               in_acc;
    logic               out_acc;

    cmos_inv_cell #(.WIDTH(WIDTH)) u_pol_inv (
        .x (in_data),
        .y (pol_inv)
    );

    assign head_data = pol ? pol_inv : in_data;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [WIDTH-1:0] src;

        if (s == 0) begin : g_head
            assign src = head_data;
        end else begin : g_body
            assign src = stage_data[s-1];
        end

        if (INV_MASK[s]) begin : g_inv
            wire [WIDTH-1:0] inv_out;
            cmos_inv_cell #(.WIDTH(WIDTH)) u_inv (
                .x (src),
                .y (inv_out)
            );
            assign stage_in[s] = inv_out;
        end else begin : g_pass
            assign stage_in[s] = src;
        end
    end

    // A stage may advance if any stage downstream of it is empty or the sink
    // accepts; written non-recursively so the ready chain has no comb loop.
    always_comb begin
        logic adv;
        src_valid = DEPTH'({valid_q, in_valid});
        for (int s = 0; s < DEPTH; s++) begin
            adv = out_ready;
            for (int t = s + 1; t < DEPTH; t++) begin
                if (!valid_q[t]) adv = 1'b1;
            end
            ctl[s].valid = valid_q[s];
            ctl[s].adv   = adv;
            load[s]      = !ctl[s].valid || ctl[s].adv;
        end
    end

    assign in_ready  = !rst && load[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    // Data only captures a valid word, so idle X never enters and empty stages hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) stage_data[s] <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (load[s]) begin
                    valid_q[s] <= src_valid[s];
                    if (src_valid[s]) stage_data[s] <= stage_in[s];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (in_acc && !out_acc) begin
            count <= count + 1'b1;
        end else if (!in_acc && out_acc) begin
            count <= count - 1'b1;
        end
    end

`ifdef CMOS_INV_PIPELINE_PARITY_EN
    // Inverting an even-width word leaves its parity unchanged.
    localparam logic ODD_W = ((WIDTH % 2) == 1);

    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_in;

    always_comb begin
        par_in    = '0;
        par_in[0] = (^in_data) ^ (pol & ODD_W) ^ (INV_MASK[0] & ODD_W);
        for (int s = 1; s < DEPTH; s++) begin
            par_in[s] = par_q[s-1] ^ (INV_MASK[s] & ODD_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (load[s] && src_valid[s]) par_q[s] <= par_in[s];
            end
        end
    end

    assign out_par = par_q[DEPTH-1];
    assign par_err = out_valid && (out_par != ^out_data);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmos_inv_pipeline.sv
// tb_cmos_inv_pipeline: directed table-driven bench for cmos_inv_pipeline
// (WIDTH=8, DEPTH=4, INV_MASK=0101); parity section under CMOS_INV_PIPELINE_PARITY_EN.
`default_nettype none

module tb_cmos_inv_pipeline;

    typedef struct {
        logic [7:0] data;
        logic       pol;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       pol;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int   errors;
    int   checks;
    int   cyc;
    bit   chk_lat;
    bit   last_in_acc;
    exp_t sb [$];
    vec_t tbl [8];

`ifdef CMOS_INV_PIPELINE_PARITY_EN
    logic       out_par;
    logic       par_err;
    logic       p_in_valid;
    logic       p_in_ready;
    logic [6:0] p_in_data;
    logic       p_pol;
    logic       p_out_valid;
    logic       p_out_ready;
    logic [6:0] p_out_data;
    logic [2:0] p_count;
    logic       p_out_par;
    logic       p_par_err;
`endif

    cmos_inv_pipeline #(.WIDTH(8), .DEPTH(4), .INV_MASK(4'b0101)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pol       (pol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef CMOS_INV_PIPELINE_PARITY_EN
        ,
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

`ifdef CMOS_INV_PIPELINE_PARITY_EN
    cmos_inv_pipeline #(.WIDTH(7), .DEPTH(4), .INV_MASK(4'b0001)) p_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_data   (p_in_data),
        .pol       (p_pol),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_data  (p_out_data),
        .count     (p_count),
        .out_par   (p_out_par),
        .par_err   (p_par_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Inputs are already set; sample away from the edge, score, then advance one cycle.
    task automatic step(input logic [7:0] exp_word);
        exp_t e;
        #1;
        check("count", 32'(count), 32'(sb.size()));
        if (chk_lat) begin
            if (sb.size() > 0) check("out_valid", 32'(out_valid), 32'(sb[0].due == cyc));
            else               check("out_valid", 32'(out_valid), 32'd0);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.exp));
                if (chk_lat) check("latency", 32'(cyc), 32'(e.due));
            end
`ifdef CMOS_INV_PIPELINE_PARITY_EN
            check("par_err_clean", 32'(par_err), 32'd0);
`endif
        end
        last_in_acc = in_valid && in_ready;
        if (last_in_acc) sb.push_back('{exp_word, cyc + 4});
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        in_data  = 'x;
        pol      = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) step(8'h00);
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic fill4(input logic [7:0] base);
        int n;
        n = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 20 && n < 4; t++) begin
            in_valid = 1'b1;
            in_data  = 8'(base + n);
            pol      = 1'b0;
            step(8'(base + n));
            if (last_in_acc) n++;
        end
        check("fill_accepts", 32'(n), 32'd4);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        errors = 0;
        checks = 0;
        cyc    = 0;
        chk_lat = 1'b0;

        tbl[0] = '{8'hA5, 1'b0, 8'hA5};
        tbl[1] = '{8'hA5, 1'b1, 8'h5A};
        tbl[2] = '{8'h00, 1'b0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 8'h00};
        tbl[4] = '{8'h3C, 1'b0, 8'h3C};
        tbl[5] = '{8'h81, 1'b1, 8'h7E};
        tbl[6] = '{8'h12, 1'b0, 8'h12};
        tbl[7] = '{8'hC3, 1'b1, 8'h3C};

        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; pol = 1'b0; out_ready = 1'b1;
`ifdef CMOS_INV_PIPELINE_PARITY_EN
        p_in_valid = 1'b0; p_in_data = '0; p_pol = 1'b0; p_out_ready = 1'b1;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Streaming at full rate, fixed latency of 4.
        chk_lat = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].data;
            pol      = tbl[i].pol;
            step(tbl[i].exp);
        end
        drain();

        // Backpressure: four words fill the pipe, then it must stall.
        chk_lat = 1'b0;
        fill4(8'h10);
        in_valid = 1'b1; in_data = 8'h14;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'h10);
            step(8'h14);
        end
        out_ready = 1'b1;
        n = 4;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_release_valid", 32'(out_valid), 32'd1);
            in_valid = (n < 6);
            in_data  = 8'(8'h10 + n);
            step(8'(8'h10 + n));
            if (last_in_acc) n++;
        end
        check("bp_total_accepts", 32'(n), 32'd6);
        drain();

        // Full pipe with simultaneous input and output accepts.
        fill4(8'h20);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            pol      = i[0];
            d        = 8'(8'h30 + i);
            in_data  = d;
            #1;
            check("sim_in_ready", 32'(in_ready), 32'd1);
            step(d ^ {8{i[0]}});
        end
        drain();

        // Bubbles: alternate valid, idle data is X.
        chk_lat = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = ~i[0];
            pol      = 1'b0;
            if (i[0]) in_data = 'x;
            else      in_data = 8'(8'h40 + i);
            step(8'(8'h40 + i));
            check("bubble_count_le2", 32'(count <= 3'd2), 32'd1);
        end
        drain();
        repeat (3) step(8'h00);
        check("hold_after_x", 32'(out_data), 32'h46);

        // Reset with three words in flight.
        chk_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            pol      = 1'b0;
            step(8'(8'h50 + i));
        end
        rst = 1'b1;
        #1;
        check("midrst_count",     32'(count),     32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_data = 'x;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("post_rst_no_out", 32'(out_valid), 32'd0);
            step(8'h00);
        end

`ifdef CMOS_INV_PIPELINE_PARITY_EN
        for (int w = 0; w < 3; w++) begin
            p_in_valid = 1'b1; p_in_data = 7'h01; p_pol = 1'b0;
            @(negedge clk);
            p_in_valid = 1'b0; p_in_data = 'x;
            for (int t = 0; t < 10 && !p_out_valid; t++) @(negedge clk);
            #1;
            check("par_out_valid", 32'(p_out_valid), 32'd1);
            check("par_out_data",  32'(p_out_data),  32'h7E);
            check("par_out_par",   32'(p_out_par),   32'd0);
            if (w == 1) begin
                force p_dut.out_data = 7'h7F;
                #1;
                check("par_err_forced", 32'(p_par_err), 32'd1);
                release p_dut.out_data;
                #1;
            end
            check("par_err_word", 32'(p_par_err), 32'd0);
            @(negedge clk);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
